glsu_cluster_sequencer: RTL and testbench

- Sequences vector requests from the global dispatcher to all NrClusters cluster dispatchers.
- Tracks outstanding loads and stores until the GLSU address generators acknowledge them.
- Holds off configuration (vset*) requests while memory operations are in flight, so vl and vtype never change under an active load or store.
- Sits between the CVA6 accelerator port and the per-cluster request interfaces.

---
 rtl/glsu_cluster_sequencer.sv | 93 +++++++++
 tb/tb_glsu_cluster_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/glsu_cluster_sequencer.sv
// glsu_cluster_sequencer: broadcasts vector requests to every cluster and tracks in-flight loads/stores.
// Optional stall/broadcast performance counters are enabled with GLSU_SEQ_PERF_EN.
module glsu_cluster_sequencer #(
  parameter int NrClusters     = 4,
  parameter int MaxOutstanding = 4,
  parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [1:0]            req_kind_i,
  output logic                  req_ready_o,
  output logic [NrClusters-1:0] cluster_valid_o,
  input  logic [NrClusters-1:0] cluster_ready_i,
  input  logic                  ar_addrgen_ack_i,
  input  logic                  aw_addrgen_ack_i,
  output logic [CntW-1:0]       ld_outstanding_o,
  output logic [CntW-1:0]       st_outstanding_o,
  output logic                  busy_o,
  output logic                  ack_err_o
`ifdef GLSU_SEQ_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           bcast_cycles_o
`endif
);
  typedef enum logic [1:0] {IDLE, DRAIN, BCAST} state_t;
  localparam logic [CntW-1:0] MAX = CntW'(MaxOutstanding);
  state_t state, state_n;
  logic [1:0] kind, kind_n;
  logic [NrClusters-1:0] mask, mask_n, acc;
  logic [CntW-1:0] ld_n, st_n;
  logic done, ld_dec, st_dec, stall;
  assign cluster_valid_o = state == BCAST ? ~mask : '0;
  assign acc = mask | (cluster_valid_o & cluster_ready_i);
  assign done = state == BCAST && &acc;
  assign req_ready_o = done;
  // acks against an empty counter are errors and never wrap the count
  assign ld_dec = ar_addrgen_ack_i && ld_outstanding_o != '0;
  assign st_dec = aw_addrgen_ack_i && st_outstanding_o != '0;
  assign ld_n = ld_outstanding_o + CntW'(done && kind == 2'd1) - CntW'(ld_dec);
  assign st_n = st_outstanding_o + CntW'(done && kind == 2'd2) - CntW'(st_dec);
  assign stall = (req_kind_i == 2'd1 && ld_outstanding_o == MAX) ||
                 (req_kind_i == 2'd2 && st_outstanding_o == MAX);
  assign busy_o = state != IDLE || ld_outstanding_o != '0 || st_outstanding_o != '0;
  always_comb begin
    state_n = state;
    kind_n  = kind;
    mask_n  = mask;
    case (state)
      IDLE: if (req_valid_i) begin
        kind_n  = req_kind_i;
        mask_n  = '0;
        state_n = (req_kind_i == 2'd3 && busy_o) ? DRAIN : stall ? IDLE : BCAST;
      end
      DRAIN: state_n = (ld_n == '0 && st_n == '0) ? BCAST : DRAIN;
      BCAST: begin
        mask_n  = acc;
        state_n = done ? IDLE : BCAST;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state            <= IDLE;
      kind             <= '0;
      mask             <= '0;
      ld_outstanding_o <= '0;
      st_outstanding_o <= '0;
      ack_err_o        <= 1'b0;
    end else begin
      state            <= state_n;
      kind             <= kind_n;
      mask             <= mask_n;
      ld_outstanding_o <= ld_n;
      st_outstanding_o <= st_n;
      ack_err_o        <= ack_err_o | (ar_addrgen_ack_i && !ld_dec) | (aw_addrgen_ack_i && !st_dec);
    end
`ifdef GLSU_SEQ_PERF_EN
  logic stall_cyc, bcast_cyc;
  assign stall_cyc = req_valid_i && (state == DRAIN || (state == IDLE && stall));
  assign bcast_cyc = state == BCAST && !done;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stall_cycles_o <= '0;
      bcast_cycles_o <= '0;
    end else begin
      stall_cycles_o <= stall_cycles_o + 32'(stall_cyc && stall_cycles_o != '1);
      bcast_cycles_o <= bcast_cycles_o + 32'(bcast_cyc && bcast_cycles_o != '1);
    end
`endif
endmodule

// File: tb/tb_glsu_cluster_sequencer.sv
// tb_glsu_cluster_sequencer: directed test-plan steps plus random traffic against a cycle-level reference model.
module tb_glsu_cluster_sequencer;
  localparam int N = 4, MAX = 4, CW = $clog2(MAX + 1);
  logic clk = 0, rst = 1, req_valid = 0, ar_ack = 0, aw_ack = 0;
  logic [1:0] req_kind = 0;
  logic [N-1:0] cluster_ready = 0;
  logic req_ready, busy, ack_err;
  logic [N-1:0] cluster_valid;
  logic [CW-1:0] ld_out, st_out;
  int total = 0, bad = 0;
  int m_ld, m_st, m_phase;
  bit m_err, m_done;
  logic [N-1:0] m_got;
  logic [1:0] m_kind;
  always #5 clk = ~clk;
  glsu_cluster_sequencer #(.NrClusters(N), .MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_kind_i(req_kind),
    .req_ready_o(req_ready), .cluster_valid_o(cluster_valid), .cluster_ready_i(cluster_ready),
    .ar_addrgen_ack_i(ar_ack), .aw_addrgen_ack_i(aw_ack),
    .ld_outstanding_o(ld_out), .st_outstanding_o(st_out), .busy_o(busy), .ack_err_o(ack_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set(input logic rv, input logic [1:0] k, input logic [N-1:0] rdy, input logic ar, input logic aw);
    req_valid = rv; req_kind = k; cluster_ready = rdy; ar_ack = ar; aw_ack = aw;
    #1;
  endtask
  task automatic model_reset();
    m_ld = 0; m_st = 0; m_phase = 0; m_err = 0; m_got = '0; m_kind = '0; m_done = 0;
  endtask
  // phase: 0 waiting for a request, 1 waiting for memory ops to retire, 2 handing out to clusters
  task automatic cyc();
    logic [N-1:0] cv, nw;
    int nld, nst;
    cv = (m_phase == 2) ? ~m_got : '0;
    nw = cv & cluster_ready;
    m_done = (m_phase == 2) && ((m_got | nw) == '1);
    chk("cluster_valid", 32'(cluster_valid), 32'(cv));
    chk("req_ready", 32'(req_ready), 32'(m_done));
    chk("ld_outstanding", 32'(ld_out), 32'(m_ld));
    chk("st_outstanding", 32'(st_out), 32'(m_st));
    chk("busy", 32'(busy), 32'(m_phase != 0 || m_ld != 0 || m_st != 0));
    chk("ack_err", 32'(ack_err), 32'(m_err));
    nld = m_ld + ((m_done && m_kind == 1) ? 1 : 0) - ((ar_ack && m_ld > 0) ? 1 : 0);
    nst = m_st + ((m_done && m_kind == 2) ? 1 : 0) - ((aw_ack && m_st > 0) ? 1 : 0);
    if ((ar_ack && m_ld == 0) || (aw_ack && m_st == 0)) m_err = 1;
    if (m_phase == 0) begin
      if (req_valid) begin
        m_kind = req_kind; m_got = '0;
        if (req_kind == 3 && (m_ld > 0 || m_st > 0)) m_phase = 1;
        else if (!((req_kind == 1 && m_ld == MAX) || (req_kind == 2 && m_st == MAX))) m_phase = 2;
      end
    end else if (m_phase == 1) begin
      if (nld == 0 && nst == 0) begin m_phase = 2; m_got = '0; end
    end else if (m_done) m_phase = 0;
    else m_got = m_got | nw;
    m_ld = nld; m_st = nst;
    @(posedge clk); #1;
  endtask
  task automatic run_req(input logic [1:0] k);
    set(1, k, '1, 0, 0); cyc();
    chk("quick_req_ready", 32'(req_ready), 32'd1);
    cyc();
    set(0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    #3;
    chk("reset_valid", 32'(cluster_valid), 0);
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 0;
    // single load, all clusters ready
    set(1, 1, 4'b1111, 0, 0);
    chk("t1_c0_valid", 32'(cluster_valid), 0); cyc();
    chk("t1_c1_valid", 32'(cluster_valid), 32'hF);
    chk("t1_c1_ready", 32'(req_ready), 1); cyc();
    set(0, 0, 0, 0, 0);
    chk("t1_c2_ld", 32'(ld_out), 1);
    // store with staggered accepts
    set(1, 2, 4'b0000, 0, 0); cyc();
    set(1, 2, 4'b0011, 0, 0); chk("t2_c1_valid", 32'(cluster_valid), 32'hF); cyc();
    set(1, 2, 4'b0000, 0, 0); chk("t2_c2_valid", 32'(cluster_valid), 32'hC); cyc();
    set(1, 2, 4'b0100, 0, 0); chk("t2_c3_ready", 32'(req_ready), 0); cyc();
    set(1, 2, 4'b0000, 0, 0); chk("t2_c4_valid", 32'(cluster_valid), 32'h8); cyc();
    set(1, 2, 4'b1000, 0, 0); chk("t2_c5_ready", 32'(req_ready), 1); cyc();
    set(0, 0, 0, 0, 0);
    chk("t2_valid_done", 32'(cluster_valid), 0);
    chk("t2_st", 32'(st_out), 1);
    // fill loads to the limit, then stall
    repeat (3) run_req(1);
    chk("t3_ld_full", 32'(ld_out), MAX);
    set(1, 1, 4'b1111, 0, 0); cyc();
    repeat (2) begin chk("t3_stall_ready", 32'(req_ready), 0); cyc(); end
    set(1, 1, 4'b1111, 1, 0); cyc();
    set(1, 1, 4'b1111, 0, 0); chk("t3_ld_freed", 32'(ld_out), MAX - 1); cyc();
    chk("t3_fifth_ready", 32'(req_ready), 1); cyc();
    set(0, 0, 0, 0, 0);
    chk("t3_ld_again", 32'(ld_out), MAX);
    // config waits for memory ops to drain
    set(0, 0, 0, 1, 0); cyc(); cyc();
    set(1, 3, 4'b1111, 0, 0); chk("t4_ld2", 32'(ld_out), 2); cyc();
    set(1, 3, 4'b1111, 1, 1); chk("t4_drain_valid", 32'(cluster_valid), 0); chk("t4_drain_busy", 32'(busy), 1); cyc();
    set(1, 3, 4'b1111, 1, 0); chk("t4_drain_valid2", 32'(cluster_valid), 0); cyc();
    set(1, 3, 4'b1111, 0, 0); chk("t4_bcast_valid", 32'(cluster_valid), 32'hF); chk("t4_bcast_ready", 32'(req_ready), 1); cyc();
    set(0, 0, 0, 0, 0);
    // same-cycle increment and decrement, then error on empty
    run_req(2);
    set(1, 2, 4'b1111, 0, 0); cyc();
    set(1, 2, 4'b1111, 0, 1); chk("t5_ready", 32'(req_ready), 1); cyc();
    set(0, 0, 0, 0, 0); chk("t5_st_same", 32'(st_out), 1); chk("t5_no_err", 32'(ack_err), 0);
    set(0, 0, 0, 0, 1); cyc(); cyc();
    set(0, 0, 0, 0, 0); chk("t5_err", 32'(ack_err), 1); chk("t5_st0", 32'(st_out), 0);
    // asynchronous reset mid-broadcast
    set(1, 0, 4'b0000, 0, 0); cyc();
    set(1, 0, 4'b0101, 0, 0); cyc();
    set(1, 0, 4'b0000, 0, 0); chk("t6_mask_valid", 32'(cluster_valid), 32'hA);
    #2 rst = 1; #1;
    chk("t6_rst_valid", 32'(cluster_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_err", 32'(ack_err), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    set(1, 0, 4'b1111, 0, 0); cyc();
    chk("t6_rebcast_valid", 32'(cluster_valid), 32'hF); cyc();
    set(0, 0, 0, 0, 0);
    // random traffic
    begin
      bit on = 0;
      logic [1:0] k = 0;
      for (int i = 0; i < 600; i++) begin
        if (!on && $urandom_range(2) == 0) begin on = 1; k = 2'($urandom_range(3)); end
        set(on, k, N'($urandom), (m_ld > 0) ? ($urandom_range(3) == 0) : ($urandom_range(99) == 0),
            (m_st > 0) ? ($urandom_range(3) == 0) : ($urandom_range(99) == 0));
        cyc();
        if (m_done) on = 0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
